uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NREQ byte requesters.
// Runs the tx_start/tx_busy handshake per byte, supports per-requester lock and start timeout.
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ-1:0]          req_lock,
    output logic [NREQ-1:0]          req_ack,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(NREQ)-1:0]  owner_id,
    output logic                     active
);

    localparam int unsigned IdW  = $clog2(NREQ);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StStart, StBusy} state_e;

    state_e            state_q, state_d;
    logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]    owner_d;
    logic              locked_q, locked_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] data_d;
    logic [NREQ-1:0]   ack_d;
    logic              start_d, done_d, err_d, active_d;
    logic              finish;

    logic              grant_ok;
    logic [IdW-1:0]    grant_idx;
    logic [IdW-1:0]    cand;

    // While locked only the owner may win; otherwise search cyclically from rr_ptr.
    always_comb begin
        grant_ok  = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (locked_q) begin
            if (req_valid[owner_id]) begin
                grant_ok  = 1'b1;
                grant_idx = owner_id;
            end
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = IdW'((32'(rr_ptr_q) + k) % NREQ);
                if (!grant_ok && req_valid[cand]) begin
                    grant_ok  = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_id;
        locked_d = locked_q;
        cnt_d    = cnt_q;
        data_d   = tx_data;
        ack_d    = '0;
        start_d  = tx_start;
        done_d   = 1'b0;
        err_d    = 1'b0;
        active_d = active;
        finish   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_ok) begin
                    state_d          = StStart;
                    owner_d          = grant_idx;
                    data_d           = req_data[grant_idx*DATA_W +: DATA_W];
                    ack_d[grant_idx] = 1'b1;
                    cnt_d            = '0;
                    start_d          = 1'b1;
                    active_d         = 1'b1;
                end else if (locked_q && !req_valid[owner_id] && !req_lock[owner_id]) begin
                    locked_d = 1'b0;
                end
            end
            StStart: begin
                // cnt_q holds the number of START cycles already elapsed without busy
                if (tx_busy) begin
                    state_d = StBusy;
                    start_d = 1'b0;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    err_d  = 1'b1;
                    finish = 1'b1;
                end else if (cnt_q != CntW'(TIMEOUT)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBusy: begin
                if (!tx_busy) begin
                    done_d = 1'b1;
                    finish = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (finish) begin
            state_d  = StIdle;
            start_d  = 1'b0;
            active_d = 1'b0;
            if (req_lock[owner_id]) begin
                locked_d = 1'b1;
            end else begin
                locked_d = 1'b0;
                rr_ptr_d = (owner_id == IdW'(NREQ - 1)) ? '0 : owner_id + 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            owner_id <= '0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
            tx_data  <= '0;
            req_ack  <= '0;
            tx_start <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            active   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_id <= owner_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
            tx_data  <= data_d;
            req_ack  <= ack_d;
            tx_start <= start_d;
            done     <= done_d;
            err      <= err_d;
            active   <= active_d;
        end
    end

endmodule
